// File: rtl/wb_resolve_unit.sv
// Writeback and branch-resolution stage for the pipelined LC-3b-style core.
// Commits one instruction per cycle. Produces the registered register-file
// write and owns the NZP condition codes. Resolves BR/JMP/TRAP into a
// registered fetch redirect, and queues BTB updates in a small FIFO.
module wb_resolve_unit #(
  parameter int WIDTH         = 16,
  parameter int REG_BITS      = 3,
  parameter int DEPTH         = 4,
  parameter int UPD_NOT_TAKEN = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       ins_is_br,
  input  logic                       ins_is_jmp,
  input  logic                       ins_is_trap,
  input  logic                       ins_load_cc,
  input  logic                       ins_load_reg,
  input  logic [2:0]                 ins_nzp,
  input  logic [REG_BITS-1:0]        ins_dest,
  input  logic [WIDTH-1:0]           ins_pc,
  input  logic [WIDTH-1:0]           ins_target,
  input  logic [WIDTH-1:0]           ins_result,
  output logic                       rf_we,
  output logic [REG_BITS-1:0]        rf_dest,
  output logic [WIDTH-1:0]           rf_data,
  output logic [2:0]                 cc_out,
  output logic                       redirect_valid,
  output logic [WIDTH-1:0]           redirect_pc,
  output logic                       upd_valid,
  input  logic                       upd_ready,
  output logic [WIDTH-1:0]           upd_pc,
  output logic [WIDTH-1:0]           upd_target,
  output logic                       upd_taken,
  output logic [$clog2(DEPTH):0]     upd_count
);

  localparam int                 PTR_W    = $clog2(DEPTH);
  localparam int                 CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);
  localparam logic               NT_EN    = (UPD_NOT_TAKEN != 0);

  // NZP encoding of a writeback value: sign bit first, then zero, else positive.
  function automatic logic [2:0] f_cc(input logic [WIDTH-1:0] v);
    logic [2:0] cc;
    if (v[WIDTH-1]) begin
      cc = 3'b100;
    end else if (v == {WIDTH{1'b0}}) begin
      cc = 3'b010;
    end else begin
      cc = 3'b001;
    end
    return cc;
  endfunction

  // Architectural state
  logic [2:0]          r_cc;
  logic                r_rf_we;
  logic [REG_BITS-1:0] r_rf_dest;
  logic [WIDTH-1:0]    r_rf_data;
  logic                r_redir_valid;
  logic [WIDTH-1:0]    r_redir_pc;

  // Update FIFO storage and bookkeeping
  logic [WIDTH-1:0]    r_mem_pc  [DEPTH];
  logic [WIDTH-1:0]    r_mem_tgt [DEPTH];
  logic                r_mem_tk  [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  // Combinational decode
  logic                w_commit;
  logic                w_taken;
  logic                w_redirect;
  logic                w_push;
  logic                w_pop;
  logic                w_entry_taken;
  logic                w_upd_valid;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [WIDTH-1:0]    w_redir_pc_nxt;

  // Ready depends only on registered occupancy, never on upd_ready.
  assign in_ready      = (r_count != FULL_CNT);
  assign w_commit      = in_valid & in_ready;
  // Branch resolution uses the CC as it stands before this commit.
  assign w_taken       = ins_is_br & (|(ins_nzp & r_cc));
  assign w_redirect    = ins_is_trap | ins_is_jmp | w_taken;
  assign w_entry_taken = ins_is_jmp | w_taken;
  assign w_push        = w_commit & ~ins_is_trap &
                         (ins_is_jmp | (ins_is_br & (w_taken | NT_EN)));
  assign w_upd_valid   = (r_count != {CNT_W{1'b0}});
  assign w_pop         = w_upd_valid & upd_ready;

  // Occupancy next-state: push and pop together leave the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Redirect target selection: trap vector wins over any computed target.
  always_comb begin
    w_redir_pc_nxt = r_redir_pc;
    if (ins_is_trap) begin
      w_redir_pc_nxt = ins_result;
    end else begin
      w_redir_pc_nxt = ins_target;
    end
  end

  // Writeback, condition codes and redirect registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cc          <= 3'b010;
      r_rf_we       <= 1'b0;
      r_rf_dest     <= {REG_BITS{1'b0}};
      r_rf_data     <= {WIDTH{1'b0}};
      r_redir_valid <= 1'b0;
      r_redir_pc    <= {WIDTH{1'b0}};
    end else begin
      r_rf_we       <= w_commit & ins_load_reg;
      r_redir_valid <= w_commit & w_redirect;
      if (w_commit & ins_load_reg) begin
        r_rf_dest <= ins_dest;
        r_rf_data <= ins_result;
      end
      if (w_commit & ins_load_cc) begin
        r_cc <= f_cc(ins_result);
      end
      if (w_commit & w_redirect) begin
        r_redir_pc <= w_redir_pc_nxt;
      end
    end
  end

  // FIFO storage writes and pointer/occupancy updates; reset drops all entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]  <= {WIDTH{1'b0}};
        r_mem_tgt[i] <= {WIDTH{1'b0}};
        r_mem_tk[i]  <= 1'b0;
      end
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_mem_pc[r_wr_ptr]  <= ins_pc;
        r_mem_tgt[r_wr_ptr] <= ins_target;
        r_mem_tk[r_wr_ptr]  <= w_entry_taken;
        r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  assign rf_we          = r_rf_we;
  assign rf_dest        = r_rf_dest;
  assign rf_data        = r_rf_data;
  assign cc_out         = r_cc;
  assign redirect_valid = r_redir_valid;
  assign redirect_pc    = r_redir_pc;
  assign upd_valid      = w_upd_valid;
  assign upd_count      = r_count;
  // Head fields come straight from storage and read as zero while empty.
  assign upd_pc         = w_upd_valid ? r_mem_pc[r_rd_ptr]  : {WIDTH{1'b0}};
  assign upd_target     = w_upd_valid ? r_mem_tgt[r_rd_ptr] : {WIDTH{1'b0}};
  assign upd_taken      = w_upd_valid ? r_mem_tk[r_rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_wb_resolve_unit.sv
// Directed self-checking bench for wb_resolve_unit. Two instances share the
// inputs: dut enqueues not-taken BRs, dut0 enqueues taken updates only.
module tb_wb_resolve_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        ins_is_br, ins_is_jmp, ins_is_trap, ins_load_cc, ins_load_reg;
  logic [2:0]  ins_nzp;
  logic [2:0]  ins_dest;
  logic [15:0] ins_pc, ins_target, ins_result;
  logic        upd_ready;

  logic        in_ready, rf_we, redirect_valid, upd_valid, upd_taken;
  logic [2:0]  rf_dest, cc_out;
  logic [15:0] rf_data, redirect_pc, upd_pc, upd_target;
  logic [2:0]  upd_count;

  logic        in_ready_0, rf_we_0, redirect_valid_0, upd_valid_0, upd_taken_0;
  logic [2:0]  rf_dest_0, cc_out_0;
  logic [15:0] rf_data_0, redirect_pc_0, upd_pc_0, upd_target_0;
  logic [2:0]  upd_count_0;

  int n_cmp;
  int n_bad;

  wb_resolve_unit #(.WIDTH(16), .REG_BITS(3), .DEPTH(4), .UPD_NOT_TAKEN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ins_is_br(ins_is_br), .ins_is_jmp(ins_is_jmp), .ins_is_trap(ins_is_trap),
    .ins_load_cc(ins_load_cc), .ins_load_reg(ins_load_reg), .ins_nzp(ins_nzp),
    .ins_dest(ins_dest), .ins_pc(ins_pc), .ins_target(ins_target),
    .ins_result(ins_result), .rf_we(rf_we), .rf_dest(rf_dest), .rf_data(rf_data),
    .cc_out(cc_out), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken), .upd_count(upd_count)
  );

  wb_resolve_unit #(.WIDTH(16), .REG_BITS(3), .DEPTH(4), .UPD_NOT_TAKEN(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_0),
    .ins_is_br(ins_is_br), .ins_is_jmp(ins_is_jmp), .ins_is_trap(ins_is_trap),
    .ins_load_cc(ins_load_cc), .ins_load_reg(ins_load_reg), .ins_nzp(ins_nzp),
    .ins_dest(ins_dest), .ins_pc(ins_pc), .ins_target(ins_target),
    .ins_result(ins_result), .rf_we(rf_we_0), .rf_dest(rf_dest_0), .rf_data(rf_data_0),
    .cc_out(cc_out_0), .redirect_valid(redirect_valid_0), .redirect_pc(redirect_pc_0),
    .upd_valid(upd_valid_0), .upd_ready(upd_ready), .upd_pc(upd_pc_0),
    .upd_target(upd_target_0), .upd_taken(upd_taken_0), .upd_count(upd_count_0)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one instruction for one clock edge, then withdraw in_valid.
  // Outputs are examined 1 ns after the edge.
  task automatic issue(input logic br, input logic jmp, input logic trap,
                       input logic lcc, input logic lreg, input logic [2:0] nzp,
                       input logic [2:0] dest, input logic [15:0] pc,
                       input logic [15:0] tgt, input logic [15:0] res);
    in_valid     = 1'b1;
    ins_is_br    = br;
    ins_is_jmp   = jmp;
    ins_is_trap  = trap;
    ins_load_cc  = lcc;
    ins_load_reg = lreg;
    ins_nzp      = nzp;
    ins_dest     = dest;
    ins_pc       = pc;
    ins_target   = tgt;
    ins_result   = res;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (cc_out !== 3'b010) begin n_bad++; $display("FAIL reset_cc got %b want 010", cc_out); end
    n_cmp++; if ({rf_we, rf_dest, rf_data} !== 20'h0) begin n_bad++; $display("FAIL reset_rf got %b/%h/%h want 0", rf_we, rf_dest, rf_data); end
    n_cmp++; if ({redirect_valid, redirect_pc} !== 17'h0) begin n_bad++; $display("FAIL reset_redir got %b/%h want 0", redirect_valid, redirect_pc); end
    n_cmp++; if ({upd_valid, upd_count, upd_pc, upd_target, upd_taken} !== 37'h0) begin n_bad++; $display("FAIL reset_fifo got v=%b c=%0d pc=%h t=%h tk=%b want 0", upd_valid, upd_count, upd_pc, upd_target, upd_taken); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", in_ready); end
  endtask

  task automatic test_cc();
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'd0, 16'h0, 16'h0, 16'h8000);
    n_cmp++; if (cc_out !== 3'b100) begin n_bad++; $display("FAIL cc_neg got %b want 100", cc_out); end
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'd0, 16'h0, 16'h0, 16'h0000);
    n_cmp++; if (cc_out !== 3'b010) begin n_bad++; $display("FAIL cc_zero got %b want 010", cc_out); end
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'd0, 16'h0, 16'h0, 16'h0005);
    n_cmp++; if (cc_out !== 3'b001) begin n_bad++; $display("FAIL cc_pos got %b want 001", cc_out); end
    n_cmp++; if (rf_we !== 1'b0 || redirect_valid !== 1'b0) begin n_bad++; $display("FAIL cc_no_side got we=%b rv=%b want 0/0", rf_we, redirect_valid); end
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 3'd3, 16'h2FFE, 16'h0, 16'h0000);
    n_cmp++; if (rf_we !== 1'b1 || rf_dest !== 3'd3 || rf_data !== 16'h0000) begin n_bad++; $display("FAIL b2b_rf got %b/%0d/%h want 1/3/0000", rf_we, rf_dest, rf_data); end
    // BR zero, committed the very next cycle, must see the new Z flag
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 3'd0, 16'h3000, 16'h3010, 16'h0);
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 16'h3010) begin n_bad++; $display("FAIL b2b_redir got %b/%h want 1/3010", redirect_valid, redirect_pc); end
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL b2b_we_pulse got %b want 0", rf_we); end
    n_cmp++; if (upd_valid !== 1'b1 || upd_pc !== 16'h3000 || upd_target !== 16'h3010 || upd_taken !== 1'b1 || upd_count !== 3'd1) begin n_bad++; $display("FAIL b2b_head got v=%b %h %h %b c=%0d want 1 3000 3010 1 1", upd_valid, upd_pc, upd_target, upd_taken, upd_count); end
    idle_cycle();
    n_cmp++; if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_redir_pulse got %b want 0", redirect_valid); end
    n_cmp++; if (upd_count !== 3'd1 || upd_pc !== 16'h3000) begin n_bad++; $display("FAIL b2b_head_hold got c=%0d pc=%h want 1/3000", upd_count, upd_pc); end
    upd_ready = 1'b1;
    idle_cycle();
    upd_ready = 1'b0;
    n_cmp++; if (upd_count !== 3'd0 || upd_valid !== 1'b0 || upd_count_0 !== 3'd0) begin n_bad++; $display("FAIL b2b_drain got c=%0d v=%b c0=%0d want 0/0/0", upd_count, upd_valid, upd_count_0); end
  endtask

  task automatic test_not_taken();
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'd0, 16'h0, 16'h0, 16'h0005);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 3'd0, 16'h3100, 16'h3200, 16'h0);
    n_cmp++; if (redirect_valid !== 1'b0 || redirect_valid_0 !== 1'b0) begin n_bad++; $display("FAIL nt_redir got %b/%b want 0/0", redirect_valid, redirect_valid_0); end
    n_cmp++; if (upd_count !== 3'd1 || upd_pc !== 16'h3100 || upd_target !== 16'h3200 || upd_taken !== 1'b0) begin n_bad++; $display("FAIL nt_push got c=%0d %h %h tk=%b want 1 3100 3200 0", upd_count, upd_pc, upd_target, upd_taken); end
    n_cmp++; if (upd_count_0 !== 3'd0 || upd_valid_0 !== 1'b0) begin n_bad++; $display("FAIL nt_filter got c=%0d v=%b want 0/0", upd_count_0, upd_valid_0); end
    upd_ready = 1'b1;
    idle_cycle();
    upd_ready = 1'b0;
    n_cmp++; if (upd_count !== 3'd0) begin n_bad++; $display("FAIL nt_drain got %0d want 0", upd_count); end
  endtask

  task automatic test_trap();
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'd0, 16'h3300, 16'h1234, 16'h0400);
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 16'h0400) begin n_bad++; $display("FAIL trap_redir got %b/%h want 1/0400", redirect_valid, redirect_pc); end
    n_cmp++; if (upd_count !== 3'd0 || upd_count_0 !== 3'd0) begin n_bad++; $display("FAIL trap_nopush got %0d/%0d want 0/0", upd_count, upd_count_0); end
  endtask

  task automatic test_fifo_full();
    logic [15:0] tgt;
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tgt = 16'h00A0 + 16'(i);
      issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'd0, 16'h0010 + 16'(i), tgt, 16'h0);
    end
    n_cmp++; if (in_ready !== 1'b0 || upd_count !== 3'd4) begin n_bad++; $display("FAIL full_state got rdy=%b c=%0d want 0/4", in_ready, upd_count); end
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 16'h00A3) begin n_bad++; $display("FAIL full_jmp_redir got %b/%h want 1/00A3", redirect_valid, redirect_pc); end
    // Stalled fifth instruction must leave no trace
    issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 3'd5, 16'h0014, 16'h00A4, 16'h8000);
    n_cmp++; if (upd_count !== 3'd4 || redirect_valid !== 1'b0 || rf_we !== 1'b0 || cc_out !== 3'b001) begin n_bad++; $display("FAIL full_stall got c=%0d rv=%b we=%b cc=%b want 4/0/0/001", upd_count, redirect_valid, rf_we, cc_out); end
    n_cmp++; if (upd_pc !== 16'h0010 || upd_target !== 16'h00A0) begin n_bad++; $display("FAIL full_head_stable got %h/%h want 0010/00A0", upd_pc, upd_target); end
    upd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tgt = 16'h00A0 + 16'(i);
      n_cmp++; if (upd_valid !== 1'b1 || upd_target !== tgt || upd_taken !== 1'b1) begin n_bad++; $display("FAIL drain_order[%0d] got v=%b t=%h tk=%b want 1/%h/1", i, upd_valid, upd_target, upd_taken, tgt); end
      idle_cycle();
    end
    upd_ready = 1'b0;
    n_cmp++; if (upd_valid !== 1'b0 || upd_count !== 3'd0 || in_ready !== 1'b1 || upd_count_0 !== 3'd0) begin n_bad++; $display("FAIL drain_empty got v=%b c=%0d rdy=%b c0=%0d want 0/0/1/0", upd_valid, upd_count, in_ready, upd_count_0); end
    // Streaming push+pop across the pointer wrap keeps occupancy at one
    issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'd0, 16'h0020, 16'h00B0, 16'h0);
    upd_ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      tgt = 16'h00B0 + 16'(i);
      issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'd0, 16'h0020 + 16'(i), tgt, 16'h0);
      n_cmp++; if (upd_count !== 3'd1 || upd_target !== tgt) begin n_bad++; $display("FAIL wrap[%0d] got c=%0d t=%h want 1/%h", i, upd_count, upd_target, tgt); end
    end
    idle_cycle();
    upd_ready = 1'b0;
    n_cmp++; if (upd_count !== 3'd0) begin n_bad++; $display("FAIL wrap_drain got %0d want 0", upd_count); end
  endtask

  task automatic test_reset_mid_drain();
    upd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'd0, 16'h0030 + 16'(i), 16'h00C0 + 16'(i), 16'h0);
    end
    n_cmp++; if (upd_count !== 3'd3) begin n_bad++; $display("FAIL mid_fill got %0d want 3", upd_count); end
    upd_ready = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    n_cmp++; if (upd_valid !== 1'b0 || upd_count !== 3'd0 || upd_pc !== 16'h0) begin n_bad++; $display("FAIL mid_async got v=%b c=%0d pc=%h want 0/0/0000", upd_valid, upd_count, upd_pc); end
    upd_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle_cycle();
    n_cmp++; if (upd_valid !== 1'b0 || cc_out !== 3'b010 || redirect_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_after got v=%b cc=%b rv=%b rdy=%b want 0/010/0/1", upd_valid, cc_out, redirect_valid, in_ready); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    ins_is_br = 1'b0; ins_is_jmp = 1'b0; ins_is_trap = 1'b0;
    ins_load_cc = 1'b0; ins_load_reg = 1'b0;
    ins_nzp = 3'b000; ins_dest = 3'd0;
    ins_pc = 16'h0; ins_target = 16'h0; ins_result = 16'h0;
    upd_ready = 1'b0;
    test_reset();
    test_cc();
    test_back_to_back();
    test_not_taken();
    test_trap();
    test_fifo_full();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
